// File: rtl/router_read_scheduler.sv
// router_read_scheduler: packet-aware round-robin drain of three
// router FIFOs onto one framed, parity-checked byte stream.
module router_read_scheduler #(
    parameter int ABORT_CYCLES = 32,
    parameter int CNT_W        = 6
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       vldout_0,
    input  logic       vldout_1,
    input  logic       vldout_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    input  logic       out_ready,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic [1:0] out_port,
    output logic       out_err,
    output logic       sched_busy
);

    localparam int AW = $clog2(ABORT_CYCLES + 1);
    localparam logic [CNT_W:0] ONE = (CNT_W + 1)'(1);
    localparam logic [AW-1:0] AB_LAST = AW'(ABORT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HDR, HWAIT, BODY} state_t;

    state_t         state;
    state_t         state_nx;
    logic [1:0]     rr;
    logic [1:0]     pick;
    logic [1:0]     port_nx;
    // Counts reads still to issue; one extra bit so len 63 + parity fits.
    logic [CNT_W:0] cnt;
    logic [7:0]     par;
    logic [7:0]     dat_g;
    logic [AW-1:0]  ab_cnt;
    logic [2:0]     vld;
    logic           vld_g;
    logic           rd_en;
    logic           last_rd;
    logic           abort;
    logic           rd_q;
    logic           sop_q;
    logic           eop_q;

    assign vld = {vldout_2, vldout_1, vldout_0};

    // Select status and data of the granted FIFO.
    always_comb begin
        vld_g = 1'b0;
        dat_g = 8'h00;
        unique case (out_port)
            2'd0: begin
                vld_g = vldout_0;
                dat_g = data_out_0;
            end
            2'd1: begin
                vld_g = vldout_1;
                dat_g = data_out_1;
            end
            default: begin
                vld_g = vldout_2;
                dat_g = data_out_2;
            end
        endcase
    end

    // First requester at or above the RR pointer, wrapping 2 -> 0.
    always_comb begin
        pick = 2'd0;
        unique case (rr)
            2'd0: pick = vld[0] ? 2'd0 : (vld[1] ? 2'd1 : 2'd2);
            2'd1: pick = vld[1] ? 2'd1 : (vld[2] ? 2'd2 : 2'd0);
            default: pick = vld[2] ? 2'd2 : (vld[0] ? 2'd0 : 2'd1);
        endcase
    end

    assign port_nx = (out_port == 2'd2) ? 2'd0 : out_port + 2'd1;
    assign rd_en   = out_ready && vld_g &&
                     (state == HDR || state == BODY);
    // Once the parity read is out the FSM is free to re-arbitrate;
    // the parity byte itself is flagged by eop_q on the next cycle.
    assign last_rd = (state == BODY) && rd_en && (cnt == ONE);
    assign abort   = (state == BODY) && !vld_g && (ab_cnt == AB_LAST);

    assign read_enb_0 = rd_en && (out_port == 2'd0);
    assign read_enb_1 = rd_en && (out_port == 2'd1);
    assign read_enb_2 = rd_en && (out_port == 2'd2);

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (|vld) state_nx = HDR;
            HDR:   if (rd_en) state_nx = HWAIT;
            HWAIT: state_nx = BODY;
            BODY:  if (last_rd || abort) state_nx = IDLE;
        endcase
    end

    // State, grant, counters, running parity and byte flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            rr       <= 2'd0;
            out_port <= 2'd0;
            cnt      <= '0;
            par      <= 8'h00;
            ab_cnt   <= '0;
            rd_q     <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
        end else begin
            state <= state_nx;
            rd_q  <= rd_en;
            sop_q <= rd_en && (state == HDR);
            eop_q <= last_rd;
            if (state == IDLE && |vld) out_port <= pick;
            if (last_rd || abort) rr <= port_nx;
            if (state == HWAIT) begin
                cnt <= (CNT_W + 1)'(dat_g[7:2]) + ONE;
                par <= dat_g;
            end else begin
                if (state == BODY && rd_en) cnt <= cnt - ONE;
                if (rd_q && !sop_q && !eop_q) par <= par ^ dat_g;
            end
            if (state == BODY && !vld_g && !abort)
                ab_cnt <= ab_cnt + AW'(1);
            else
                ab_cnt <= '0;
        end
    end

    assign out_valid  = rd_q || abort;
    assign out_sop    = sop_q;
    assign out_eop    = eop_q || abort;
    assign out_err    = abort || (eop_q && (dat_g != par));
    assign out_data   = rd_q ? dat_g : 8'h00;
    assign sched_busy = (state != IDLE);

endmodule

// File: tb/tb_router_read_scheduler.sv
// tb_router_read_scheduler: FIFO models, packet scoreboard and
// directed scenarios for the router read scheduler.
module tb_router_read_scheduler;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
        logic       r;
        logic [1:0] p;
    } exp_t;

    localparam int LOGN = 4096;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       out_ready = 1'b1;
    logic       vldout_0, vldout_1, vldout_2;
    logic [7:0] dout [3];
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] out_data;
    logic       out_valid, out_sop, out_eop, out_err, sched_busy;
    logic [1:0] out_port;

    logic [7:0] mem [3][256];
    int         wp [3] = '{0, 0, 0};
    int         rp [3] = '{0, 0, 0};

    exp_t       expq [$];
    int         sopq [$];
    int         eopq [$];
    int         gapq [$];
    int         portq [$];
    logic       errq [$];
    logic       vlog [LOGN];
    logic       rlog [LOGN];
    logic       olog [LOGN];
    int         rd_cnt [3] = '{0, 0, 0};
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    router_read_scheduler dut (
        .clk        (clk),
        .resetn     (resetn),
        .vldout_0   (vldout_0),
        .vldout_1   (vldout_1),
        .vldout_2   (vldout_2),
        .data_out_0 (dout[0]),
        .data_out_1 (dout[1]),
        .data_out_2 (dout[2]),
        .out_ready  (out_ready),
        .read_enb_0 (read_enb_0),
        .read_enb_1 (read_enb_1),
        .read_enb_2 (read_enb_2),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_port   (out_port),
        .out_err    (out_err),
        .sched_busy (sched_busy)
    );

    assign vldout_0 = (rp[0] != wp[0]);
    assign vldout_1 = (rp[1] != wp[1]);
    assign vldout_2 = (rp[2] != wp[2]);

    // FIFO models: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        logic [2:0] ren;
        ren = {read_enb_2, read_enb_1, read_enb_0};
        for (int p = 0; p < 3; p++) begin
            if (ren[p]) begin
                dout[p] <= mem[p][rp[p]];
                rp[p]   <= rp[p] + 1;
            end
        end
    end

    // Per-cycle checker, sampled 2 time units before each rising edge.
    always @(posedge clk) begin
        logic [2:0] rv;
        logic [2:0] vv;
        exp_t       got;
        exp_t       e;
        logic       prev_rd;
        logic       prev_rst;
        int         prev_v;
        #8;
        rv = {read_enb_2, read_enb_1, read_enb_0};
        vv = {vldout_2, vldout_1, vldout_0};
        if (cyc < LOGN) begin
            vlog[cyc] = out_valid;
            rlog[cyc] = |rv;
            olog[cyc] = out_valid | out_sop | out_eop | out_err |
                        (|out_port) | (|out_data) | (|rv) |
                        sched_busy;
        end
        if (rv != 3'b000) begin
            tests++;
            if (!$onehot(rv)) begin
                fails++;
                $display("FAIL onehot: read_enb=%b need one-hot", rv);
            end
            for (int p = 0; p < 3; p++) begin
                if (rv[p]) begin
                    rd_cnt[p]++;
                    if (!(out_ready && vv[p])) begin
                        fails++;
                        $display("FAIL rd_rule: port %0d rdy=%b vld=%b",
                                 p, out_ready, vv[p]);
                    end
                end
            end
        end
        if (prev_rd && prev_rst) begin
            tests++;
            if (!out_valid) begin
                fails++;
                $display("FAIL latency: cyc %0d out_valid=0 need 1",
                         cyc);
            end
        end
        if (!out_valid) begin
            tests++;
            if (out_sop || out_eop || out_err) begin
                fails++;
                $display("FAIL stray: sop/eop/err=%b%b%b need 000",
                         out_sop, out_eop, out_err);
            end
        end else begin
            tests++;
            got = '{out_data, out_sop, out_eop, out_err, out_port};
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexp: got %h with nothing expected",
                         got);
            end else begin
                e = expq.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL byte: cyc %0d got d=%h s%b e%b r%b p%0d want d=%h s%b e%b r%b p%0d",
                             cyc, got.d, got.s, got.e, got.r, got.p,
                             e.d, e.s, e.e, e.r, e.p);
                end
            end
            if (out_sop) begin
                sopq.push_back(cyc);
                portq.push_back(int'(out_port));
            end
            if (out_eop) begin
                eopq.push_back(cyc);
                errq.push_back(out_err);
                gapq.push_back(cyc - prev_v);
            end
            prev_v = cyc;
        end
        prev_rd  = |rv;
        prev_rst = resetn;
        cyc++;
    end

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_raw(input int p, input logic [7:0] b);
        mem[p][wp[p]] = b;
        wp[p]++;
    endtask

    task automatic exp_push(input logic [7:0] d, input logic s,
                            input logic e, input logic r, input int p);
        exp_t x;
        x = '{d, s, e, r, 2'(p)};
        expq.push_back(x);
    endtask

    // Packet model: header, payload bytes, XOR parity (or 8'hFF).
    task automatic push_pkt(input int p, input int len,
                            input logic [7:0] seed, input bit bad,
                            output logic [7:0] par);
        logic [7:0] h;
        logic [7:0] b;
        logic [7:0] last;
        h = {6'(len), 2'(p)};
        push_raw(p, h);
        exp_push(h, 1'b1, 1'b0, 1'b0, p);
        par = h;
        for (int k = 0; k < len; k++) begin
            b = seed + 8'(k * 17);
            par = par ^ b;
            push_raw(p, b);
            exp_push(b, 1'b0, 1'b0, 1'b0, p);
        end
        last = bad ? 8'hFF : par;
        push_raw(p, last);
        exp_push(last, 1'b0, 1'b1, last != par, p);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((expq.size() != 0 || sched_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL idle_to: %0d bytes left after %0d cycles",
                     expq.size(), budget);
        end
        step(2);
    endtask

    task automatic wait_sop(input int n0, input int budget);
        int n;
        n = 0;
        while (sopq.size() <= n0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL sop_to: no sop within %0d cycles", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] par;
        int ns, ne, r1, w, c, nb, np, bad;

        step(3);
        chk("reset_out0", olog[0], 0);
        chk("reset_out1", olog[1], 0);
        resetn = 1'b1;
        step(2);

        ns = sopq.size();
        ne = eopq.size();
        r1 = rd_cnt[1];
        push_pkt(1, 3, 8'h11, 1'b0, par);
        chk("par_model", par, 8'h0D);
        wait_idle(100);
        chk("rd1_pulses", rd_cnt[1] - r1, 5);
        chk("single_eops", eopq.size() - ne, 1);
        if (eopq.size() > ne && sopq.size() > ns) begin
            chk("single_span", eopq[ne] - sopq[ns], 5);
            chk("single_err", errq[ne], 0);
            chk("single_port", portq[ns], 1);
        end

        @(negedge clk);
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        step(1);
        ns = sopq.size();
        ne = eopq.size();
        push_pkt(0, 1, 8'h21, 1'b0, par);
        push_pkt(1, 1, 8'h31, 1'b0, par);
        push_pkt(2, 1, 8'h41, 1'b0, par);
        wait_idle(100);
        chk("rr_eops", eopq.size() - ne, 3);
        if (eopq.size() >= ne + 3 && sopq.size() >= ns + 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("rr_order", portq[ns + k], k);
                chk("rr_span", eopq[ne + k] - sopq[ns + k], 3);
            end
            chk("rr_gap01", sopq[ns + 1] - eopq[ne], 2);
            chk("rr_gap12", sopq[ns + 2] - eopq[ne + 1], 2);
        end
        ns = portq.size();
        push_pkt(0, 1, 8'h12, 1'b0, par);
        push_pkt(1, 0, 8'h00, 1'b0, par);
        wait_idle(100);
        if (portq.size() >= ns + 2) begin
            chk("rr_fresh0", portq[ns], 0);
            chk("rr_fresh1", portq[ns + 1], 1);
        end

        ns = sopq.size();
        push_pkt(2, 6, 8'h03, 1'b0, par);
        wait_sop(ns, 50);
        step(3);
        w = cyc;
        out_ready = 1'b0;
        step(4);
        out_ready = 1'b1;
        wait_idle(100);
        chk("bp_before", rlog[w - 1], 1);
        nb = 0;
        for (int k = 0; k < 4; k++) nb += int'(rlog[w + k]);
        chk("bp_noread", nb, 0);
        nb = 0;
        for (int k = 1; k < 5; k++) nb += int'(vlog[w + k]);
        chk("bp_novalid", nb, 0);

        ne = eopq.size();
        ns = portq.size();
        push_pkt(1, 3, 8'h11, 1'b1, par);
        step(2);
        push_pkt(0, 2, 8'h50, 1'b0, par);
        wait_idle(100);
        if (eopq.size() >= ne + 2 && portq.size() >= ns + 2) begin
            chk("perr_err", errq[ne], 1);
            chk("perr_next", errq[ne + 1], 0);
            chk("perr_port", portq[ns], 1);
            chk("perr_port2", portq[ns + 1], 0);
        end

        ne = eopq.size();
        ns = portq.size();
        push_raw(1, 8'h0D);
        push_raw(1, 8'h5A);
        exp_push(8'h0D, 1'b1, 1'b0, 1'b0, 1);
        exp_push(8'h5A, 1'b0, 1'b0, 1'b0, 1);
        exp_push(8'h00, 1'b0, 1'b1, 1'b1, 1);
        step(6);
        push_pkt(2, 1, 8'h61, 1'b0, par);
        push_pkt(0, 1, 8'h71, 1'b0, par);
        wait_idle(200);
        if (eopq.size() >= ne + 3 && portq.size() >= ns + 3) begin
            chk("abort_gap", gapq[ne], 31);
            chk("abort_err", errq[ne], 1);
            chk("abort_nx2", portq[ns + 1], 2);
            chk("abort_nx0", portq[ns + 2], 0);
        end

        ns = sopq.size();
        push_pkt(1, 5, 8'h05, 1'b0, par);
        wait_sop(ns, 50);
        step(2);
        c = cyc;
        ne = eopq.size();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        expq.delete();
        wp[1] = rp[1];
        @(negedge clk);
        resetn = 1'b1;
        step(1);
        chk("rst_outs", olog[c + 1], 0);
        chk("rst_noeop", eopq.size() - ne, 0);
        np = portq.size();
        push_pkt(0, 1, 8'h81, 1'b0, par);
        push_pkt(1, 1, 8'h91, 1'b0, par);
        wait_idle(100);
        bad = (portq.size() < np + 2) ? 1 : 0;
        chk("rst_grants", bad, 0);
        if (bad == 0) begin
            chk("rst_rr0", portq[np], 0);
            chk("rst_rr1", portq[np + 1], 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
